// File: rtl/portal_pkg.sv
// ----------------------------------------------------------------------------
// portal_pkg
// Types and helpers shared by the portal bridge blocks. The portal header
// word carries the method id in the upper half and the total word count
// (header included) in the lower half.
// ----------------------------------------------------------------------------
package portal_pkg;

   localparam int PORTAL_ID_W  = 16;
   localparam int PORTAL_LEN_W = 16;

   // One 32-bit header word: bits [31:16] = id, bits [15:0] = word count.
   typedef struct packed {
      logic [PORTAL_ID_W-1:0]  id;
      logic [PORTAL_LEN_W-1:0] len;
   } portal_hdr_t;

   // Build a header word from its fields.
   function automatic portal_hdr_t portal_hdr(input logic [PORTAL_ID_W-1:0]  id,
                                              input logic [PORTAL_LEN_W-1:0] len);
      portal_hdr_t h;
      h.id  = id;
      h.len = len;
      return h;
   endfunction

endpackage

// File: rtl/portal_ind_serializer.sv
// ----------------------------------------------------------------------------
// portal_ind_serializer
// Turns one whole indication message (id, length, up to MAX_WORDS payload
// words) into a stream of 32-bit words: a header word followed by the
// payload, one word per out__ENA strobe.
//
// Optional build macro: PORTAL_SER_PIPELINE_EN
//   When defined, a new message may be accepted in the cycle the last word
//   of the current message transfers, so messages stream back to back.
//   When undefined, a message is only accepted in IDLE (one bubble cycle).
// ----------------------------------------------------------------------------
module portal_ind_serializer
   import portal_pkg::*;
#(
   parameter  int MAX_WORDS = 4,
   localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
   input  logic                   CLK,
   input  logic                   nRST,
   // message enqueue side
   input  logic                   ind__ENA,
   input  logic [15:0]            ind__id,
   input  logic [LEN_W-1:0]       ind__len,
   input  logic [32*MAX_WORDS-1:0] ind__data,
   output logic                   ind__RDY,
   // word output side
   output logic                   out__ENA,
   output logic [31:0]            out__v,
   input  logic                   out__RDY,
   // status
   output logic                   busy,
   output logic                   lenErr
);

   localparam int                DATA_W  = 32 * MAX_WORDS;
   localparam logic [LEN_W-1:0]  MAX_LEN = LEN_W'(MAX_WORDS);
   localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_HDR  = 2'd1,
      S_DATA = 2'd2
   } state_e;

   state_e              state_q,   state_d;
   logic [DATA_W-1:0]   shreg_q,   shreg_d;
   logic [LEN_W-1:0]    rem_q,     rem_d;
   portal_hdr_t         hdr_q,     hdr_d;
   logic                len_err_q, len_err_d;

   logic                accept;
   logic [LEN_W-1:0]    eff_len;

   // Handshake outputs and status, decoded from the current state.
   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the block can leave a value unassigned and infer a latch.
      out__ENA = 1'b0;
      out__v   = 32'h0;
      busy     = (state_q != S_IDLE);
      case (state_q)
         S_HDR: begin
            out__ENA = out__RDY;
            out__v   = hdr_q;
         end
         S_DATA: begin
            out__ENA = out__RDY;
            out__v   = shreg_q[31:0];
         end
         default: begin
            out__ENA = 1'b0;
            out__v   = 32'h0;
         end
      endcase
   end

`ifdef PORTAL_SER_PIPELINE_EN
   logic last_word;

   // The final word of the message is leaving this cycle: the slot frees up.
   always_comb begin
      last_word = out__ENA &&
                  (((state_q == S_HDR)  && (rem_q == '0)) ||
                   ((state_q == S_DATA) && (rem_q == LEN_ONE)));
      ind__RDY  = (state_q == S_IDLE) || last_word;
   end
`else
   // Accept a new message only once the previous one has fully drained.
   always_comb begin
      ind__RDY = (state_q == S_IDLE);
   end
`endif

   // Clamp the requested length and form the accept strobe.
   always_comb begin
      accept  = ind__ENA && ind__RDY;
      eff_len = (ind__len > MAX_LEN) ? MAX_LEN : ind__len;
   end

   // Next-state logic: walk header then payload, shifting one word per transfer.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      rem_d     = rem_q;
      hdr_d     = hdr_q;
      len_err_d = len_err_q;

      case (state_q)
         S_HDR: begin
            if (out__ENA) begin
               state_d = (rem_q == '0) ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (out__ENA) begin
               shreg_d = shreg_q >> 32;
               rem_d   = rem_q - LEN_ONE;
               if (rem_q == LEN_ONE) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A new message overrides whatever the drain path decided; with the
      // pipelined build this is how the last-word cycle hands over directly.
      if (accept) begin
         hdr_d   = portal_hdr(ind__id, PORTAL_LEN_W'(eff_len) + PORTAL_LEN_W'(1));
         shreg_d = ind__data;
         rem_d   = eff_len;
         state_d = S_HDR;
         if (ind__len > MAX_LEN) begin
            len_err_d = 1'b1;
         end
      end
   end

   // State, datapath and sticky error registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q   <= S_IDLE;
         // NOTE: the payload shift register is cleared on reset as well, so
         // nothing from an aborted message is ever observable afterwards.
         shreg_q   <= '0;
         rem_q     <= '0;
         hdr_q     <= '0;
         len_err_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here, so every register samples
         // the next-state values computed from the same pre-edge state.
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         rem_q     <= rem_d;
         hdr_q     <= hdr_d;
         len_err_q <= len_err_d;
      end
   end

   assign lenErr = len_err_q;

endmodule
